// File: rtl/fc_align_sequencer_pkg.sv
// Shared fast-command definitions: sequencer state encoding, aligner done code
// and small helpers used by the alignment sequencer.
package fc_align_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PULSE    = 3'd1,
    S_WAITDONE = 3'd2,
    S_SETTLE   = 3'd3,
    S_CONFIRM  = 3'd4,
    S_LOCKED   = 3'd5,
    S_FAIL     = 3'd6
  } fc_state_e;

  localparam logic [3:0] ALIGN_DONE_CODE = 4'd9;

  function automatic logic is_busy(input fc_state_e s);
    return (s == S_PULSE) || (s == S_WAITDONE) || (s == S_SETTLE) || (s == S_CONFIRM);
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/fc_idle_counter.sv
// Saturating count of consecutive IDLE fast commands; any non-IDLE cycle or
// clr_i returns it to zero. Register is triplicated and majority-voted.
module fc_idle_counter #(
  parameter int MAX = 16,
  parameter bit TMR = 1'b1,
  localparam int W = $clog2(MAX + 1)
) (
  input  logic         clk40,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q [3];
  logic [W-1:0] cnt_v;
  logic [W-1:0] cnt_d;

  // NOTE: every path assigns cnt_v/cnt_d, so this block can never infer a latch.
  always_comb begin
    cnt_v = TMR ? ((cnt_q[0] & cnt_q[1]) | (cnt_q[1] & cnt_q[2]) | (cnt_q[0] & cnt_q[2]))
                : cnt_q[0];
    if (clr_i || !inc_i)        cnt_d = '0;
    else if (cnt_v == W'(MAX))  cnt_d = cnt_v;
    else                        cnt_d = cnt_v + W'(1);
  end

  // NOTE: the three copies are plain flops, not a RAM, so each one is reset;
  // non-blocking updates keep all copies sampling the same voted value.
  always_ff @(posedge clk40) begin
    for (int i = 0; i < 3; i++) begin
      if (!rstn) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d;
    end
  end

  assign cnt_o = cnt_v;

endmodule

// File: rtl/fc_align_sequencer.sv
// Drives the bit aligner through pulse / wait / settle / IDLE-confirm, retries
// on error or timeout, and monitors lock afterwards. All state is TMR-voted.
module fc_align_sequencer
  import fc_align_sequencer_pkg::*;
#(
  parameter int SETTLE_CYC = 64,
  parameter int ALIGN_TMO  = 1024,
  parameter int LOCK_IDLES = 16,
  parameter int MAX_RETRY  = 7,
  parameter bit TMR        = 1'b1
) (
  input  logic       clk40,
  input  logic       rstn,
  input  logic       start,
  input  logic       autoRelock,
  input  logic [3:0] state_bitAlign,
  input  logic       bitError,
  input  logic       fcIdle,
  output logic       fccAlign,
  output logic       busy,
  output logic       locked,
  output logic       alignFail,
  output logic [3:0] retryCnt
);

  localparam int CONFIRM_TMO = 8 * LOCK_IDLES;
  localparam int CYC_MAX_A   = (ALIGN_TMO > SETTLE_CYC) ? ALIGN_TMO : SETTLE_CYC;
  localparam int CYC_MAX     = (CYC_MAX_A > CONFIRM_TMO) ? CYC_MAX_A : CONFIRM_TMO;
  localparam int CW          = $clog2(CYC_MAX + 1);
  localparam int IW          = $clog2(LOCK_IDLES + 1);

  typedef struct packed {
    fc_state_e       state;
    logic            start;
    logic [CW-1:0]   cyc;
    logic [3:0]      retry;
    logic            fail;
    logic            miss;
  } regs_t;

  localparam int RW = $bits(regs_t);

  logic [RW-1:0] regs_q [3];
  regs_t         r;
  regs_t         n;
  logic [IW-1:0] idle_cnt;
  logic          start_edge;
  logic          align_ok;
  logic          take_retry;
  logic          enter;

  always_comb begin
    if (TMR) r = regs_t'((regs_q[0] & regs_q[1]) | (regs_q[1] & regs_q[2]) | (regs_q[0] & regs_q[2]));
    else     r = regs_t'(regs_q[0]);
  end

  assign start_edge = start & ~r.start;
  assign align_ok   = (state_bitAlign == ALIGN_DONE_CODE) && !bitError;

  always_comb begin
    n          = r;
    n.start    = start;
    n.miss     = 1'b0;
    n.cyc      = (r.cyc == CW'(CYC_MAX)) ? r.cyc : r.cyc + CW'(1);
    take_retry = 1'b0;
    enter      = 1'b0;

    case (r.state)
      S_IDLE: if (start_edge) begin
        n.retry = '0;
        n.fail  = 1'b0;
        n.state = S_PULSE;
        enter   = 1'b1;
      end
      S_PULSE: if (r.cyc == CW'(1)) begin
        n.retry = sat_inc4(r.retry);
        n.state = S_WAITDONE;
        enter   = 1'b1;
      end
      S_WAITDONE: begin
        if (bitError)                           take_retry = 1'b1;
        else if (align_ok)                      begin n.state = S_SETTLE; enter = 1'b1; end
        else if (r.cyc == CW'(ALIGN_TMO - 1))   take_retry = 1'b1;
      end
      S_SETTLE: if (r.cyc == CW'(SETTLE_CYC - 1)) begin
        n.state = S_CONFIRM;
        enter   = 1'b1;
      end
      S_CONFIRM: begin
        // Lock on the cycle whose IDLE brings the run length to LOCK_IDLES.
        if (bitError)                                         take_retry = 1'b1;
        else if (fcIdle && idle_cnt == IW'(LOCK_IDLES - 1))   begin n.state = S_LOCKED; enter = 1'b1; end
        else if (r.cyc == CW'(CONFIRM_TMO - 1))               take_retry = 1'b1;
      end
      S_LOCKED: begin
        n.miss = (state_bitAlign != ALIGN_DONE_CODE);
        if (bitError || (n.miss && r.miss)) begin
          enter = 1'b1;
          if (autoRelock) begin
            n.retry = '0;
            n.state = S_PULSE;
          end else begin
            n.state = S_IDLE;
          end
        end
      end
      S_FAIL: begin
        n.state = S_IDLE;
        enter   = 1'b1;
      end
      default: begin
        n.state = S_IDLE;
        enter   = 1'b1;
      end
    endcase

    if (take_retry) begin
      enter = 1'b1;
      if (r.retry < 4'(MAX_RETRY)) begin
        n.state = S_PULSE;
      end else begin
        n.state = S_FAIL;
        n.fail  = 1'b1;
      end
    end

    if (start_edge && (is_busy(r.state) || r.state == S_LOCKED)) begin
      n.retry = '0;
      n.state = S_PULSE;
      enter   = 1'b1;
    end

    if (enter) n.cyc = '0;
  end

  always_ff @(posedge clk40) begin
    for (int i = 0; i < 3; i++) begin
      if (!rstn) regs_q[i] <= '0;
      else       regs_q[i] <= n;
    end
  end

  fc_idle_counter #(
    .MAX (LOCK_IDLES),
    .TMR (TMR)
  ) u_idle_cnt (
    .clk40 (clk40),
    .rstn  (rstn),
    .clr_i (r.state != S_CONFIRM),
    .inc_i (fcIdle),
    .cnt_o (idle_cnt)
  );

  assign fccAlign  = (r.state == S_PULSE);
  assign busy      = is_busy(r.state);
  assign locked    = (r.state == S_LOCKED);
  assign alignFail = r.fail;
  assign retryCnt  = r.retry;

endmodule

// File: tb/tb_fc_align_sequencer.sv
// Directed bench for fc_align_sequencer: a table for the nominal lock sequence,
// then hand-written relock, IDLE-restart, retry, failure and reset scenarios.
module tb_fc_align_sequencer;

  logic       clk40 = 1'b0;
  logic       rstn;
  logic       start;
  logic       autoRelock;
  logic [3:0] state_bitAlign;
  logic       bitError;
  logic       fcIdle;
  logic       fccAlign;
  logic       busy;
  logic       locked;
  logic       alignFail;
  logic [3:0] retryCnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit         start;
    bit         bit_error;
    bit [3:0]   align;
    int         cycles;
    bit         e_fcc;
    bit         e_busy;
    bit         e_locked;
    bit         e_fail;
    bit [3:0]   e_retry;
    string      name;
  } vec_t;

  vec_t vecs [13];
  int   rise [$];
  logic prev_fcc;
  int   cyc;

  fc_align_sequencer dut (
    .clk40          (clk40),
    .rstn           (rstn),
    .start          (start),
    .autoRelock     (autoRelock),
    .state_bitAlign (state_bitAlign),
    .bitError       (bitError),
    .fcIdle         (fcIdle),
    .fccAlign       (fccAlign),
    .busy           (busy),
    .locked         (locked),
    .alignFail      (alignFail),
    .retryCnt       (retryCnt)
  );

  always #5 clk40 = ~clk40;

  task automatic tick(input int n);
    repeat (n) @(posedge clk40);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit fcc, input bit bsy, input bit lck,
                            input bit fail, input bit [3:0] retry);
    check({tag, ".fccAlign"},  32'(fccAlign),  32'(fcc));
    check({tag, ".busy"},      32'(busy),      32'(bsy));
    check({tag, ".locked"},    32'(locked),    32'(lck));
    check({tag, ".alignFail"}, 32'(alignFail), 32'(fail));
    check({tag, ".retryCnt"},  32'(retryCnt),  32'(retry));
  endtask

  function automatic vec_t mk(input bit st, input bit be, input bit [3:0] al, input int n,
                              input bit fcc, input bit bsy, input bit lck, input bit fl,
                              input bit [3:0] rt, input string nm);
    vec_t v;
    v.start = st; v.bit_error = be; v.align = al; v.cycles = n;
    v.e_fcc = fcc; v.e_busy = bsy; v.e_locked = lck; v.e_fail = fl; v.e_retry = rt;
    v.name = nm;
    return v;
  endfunction

  initial begin
    // Nominal sequence: aligner done after 20 WAITDONE cycles, fcIdle held 1.
    vecs[0]  = mk(1'b1, 1'b0, 4'd0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "pulse_c0");
    vecs[1]  = mk(1'b1, 1'b0, 4'd0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "pulse_c1");
    vecs[2]  = mk(1'b0, 1'b0, 4'd0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, "waitdone");
    vecs[3]  = mk(1'b0, 1'b0, 4'd0, 19, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, "wait_20");
    vecs[4]  = mk(1'b0, 1'b0, 4'd9,  1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, "settle");
    vecs[5]  = mk(1'b0, 1'b0, 4'd9, 63, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, "settle_end");
    vecs[6]  = mk(1'b0, 1'b0, 4'd9,  1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, "confirm");
    vecs[7]  = mk(1'b0, 1'b0, 4'd9, 15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, "confirm_15");
    vecs[8]  = mk(1'b0, 1'b0, 4'd9,  1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, "locked");
    vecs[9]  = mk(1'b0, 1'b0, 4'd0,  1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, "miss_1");
    vecs[10] = mk(1'b0, 1'b0, 4'd9,  1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, "miss_cleared");
    vecs[11] = mk(1'b0, 1'b0, 4'd3,  1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, "miss_again");
    vecs[12] = mk(1'b0, 1'b0, 4'd3,  1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, "lost_to_idle");

    rstn = 1'b0; start = 1'b0; autoRelock = 1'b0; state_bitAlign = 4'd0;
    bitError = 1'b0; fcIdle = 1'b1;
    tick(3);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rstn = 1'b1;
    tick(2);
    check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    for (int i = 0; i < 13; i++) begin
      start          = vecs[i].start;
      bitError       = vecs[i].bit_error;
      state_bitAlign = vecs[i].align;
      tick(vecs[i].cycles);
      check_outs(vecs[i].name, vecs[i].e_fcc, vecs[i].e_busy, vecs[i].e_locked,
                 vecs[i].e_fail, vecs[i].e_retry);
    end

    // Relock on bitError with autoRelock set.
    state_bitAlign = 4'd9;
    start = 1'b1; tick(1);
    check_outs("lock2_pulse", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    start = 1'b0; tick(2);
    tick(81);
    check_outs("lock2", 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
    autoRelock = 1'b1; bitError = 1'b1; tick(1);
    check_outs("relock_pulse0", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    bitError = 1'b0; tick(1);
    check("relock_pulse1.fccAlign", 32'(fccAlign), 32'd1);
    tick(1);
    check_outs("relock_wait", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    tick(81);
    check_outs("relocked", 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
    autoRelock = 1'b0;

    // Start edge while LOCKED restarts; a dropped IDLE restarts the run length.
    start = 1'b1; tick(1);
    check_outs("restart_locked", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    start = 1'b0; tick(2); tick(1); tick(64);
    fcIdle = 1'b1; tick(10);
    fcIdle = 1'b0; tick(1);
    fcIdle = 1'b1; tick(15);
    check_outs("idle_gap_15", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    tick(1);
    check_outs("idle_gap_16", 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);

    // bitError coincident with the last WAITDONE cycle: one retry only.
    start = 1'b1; tick(1);
    start = 1'b0; state_bitAlign = 4'd0; tick(2);
    tick(1023);
    check_outs("wait_last", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    bitError = 1'b1; tick(1);
    check_outs("coincident_retry", 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
    bitError = 1'b0; tick(2);
    check_outs("after_retry", 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);

    // Aligner never done: seven pulses 1026 cycles apart, then sticky failure.
    start = 1'b1; tick(1);
    start = 1'b0;
    prev_fcc = 1'b0; cyc = 0;
    while (!alignFail && cyc < 9000) begin
      if (fccAlign && !prev_fcc) rise.push_back(cyc);
      prev_fcc = fccAlign;
      tick(1);
      cyc++;
    end
    check("fail_reached.alignFail", 32'(alignFail), 32'd1);
    check("fail.pulse_count", 32'(rise.size()), 32'd7);
    for (int i = 1; i < rise.size(); i++)
      check($sformatf("fail.spacing%0d", i), 32'(rise[i] - rise[i-1]), 32'd1026);
    check_outs("fail_state", 1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
    tick(5);
    check_outs("fail_sticky", 1'b0, 1'b0, 1'b0, 1'b1, 4'd7);

    // Reset during the first PULSE cycle aborts with no trailing pulse.
    start = 1'b1; tick(1);
    check_outs("new_start", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    start = 1'b0; rstn = 1'b0; tick(1);
    check_outs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    rstn = 1'b1; tick(1);
    check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
